// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU controls, FSM states.
package multicycle_controller_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned ALUCTL_W = 3;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

   localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   typedef enum logic [3:0] {
      S_RESET   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXECUTE = 4'd7,
      S_ALUWB   = 4'd8,
      S_BEQ     = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JUMP    = 4'd12
   } state_t;

   function automatic logic op_supported(input logic [OP_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and status in, mux selects and enables out.
interface multicycle_controller_if;
   import multicycle_controller_pkg::*;

   logic [OP_W-1:0]     iOp;
   logic [FUNCT_W-1:0]  iFunct;
   logic                iZero;
   logic                iMemReady;
   logic                oIorD;
   logic                oMemWrite;
   logic                oIRWrite;
   logic                oRegDst;
   logic                oMemToReg;
   logic                oRegWrite;
   logic                oALUSrcA;
   logic [1:0]          oALUSrcB;
   logic [1:0]          oPCSrc;
   logic                oPCEn;
   logic [ALUCTL_W-1:0] oALUControl;
   logic                oRetire;
   logic                oIllegal;

   modport slave (
      input  iOp, iFunct, iZero, iMemReady,
      output oIorD, oMemWrite, oIRWrite, oRegDst, oMemToReg, oRegWrite, oALUSrcA,
             oALUSrcB, oPCSrc, oPCEn, oALUControl, oRetire, oIllegal
   );

   modport master (
      output iOp, iFunct, iZero, iMemReady,
      input  oIorD, oMemWrite, oIRWrite, oRegDst, oMemToReg, oRegWrite, oALUSrcA,
             oALUSrcB, oPCSrc, oPCEn, oALUControl, oRetire, oIllegal
   );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALUOp + funct -> ALU control; funct_valid_o also serves the illegal R-type check in DECODE.
module multicycle_controller_alu_decoder
   import multicycle_controller_pkg::*;
(
   input  aluop_t              alu_op_i,
   input  logic [FUNCT_W-1:0]  funct_i,
   output logic [ALUCTL_W-1:0] alu_control_o,
   output logic                funct_valid_o
);

   logic [ALUCTL_W-1:0] funct_ctl;

   always_comb begin
      funct_ctl     = ALU_ADD;
      funct_valid_o = 1'b1;
      case (funct_i)
         FUNCT_ADD: funct_ctl = ALU_ADD;
         FUNCT_SUB: funct_ctl = ALU_SUB;
         FUNCT_AND: funct_ctl = ALU_AND;
         FUNCT_OR:  funct_ctl = ALU_OR;
         FUNCT_SLT: funct_ctl = ALU_SLT;
         default:   funct_valid_o = 1'b0;
      endcase
   end

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD:   alu_control_o = ALU_ADD;
         ALUOP_SUB:   alu_control_o = ALU_SUB;
         ALUOP_FUNCT: alu_control_o = funct_ctl;
         default:     alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: Moore outputs from state, memory-ready stalls, PC enable gating.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic                   iClk,
   input  logic                   iRstN,
   multicycle_controller_if.slave bus
);

   state_t              state_q, state_d;
   aluop_t              alu_op_c;
   logic                pc_write_c;
   logic                branch_c;
   logic                ready_c;
   logic                funct_valid_c;
   logic                illegal_c;
   logic [ALUCTL_W-1:0] alu_ctl_c;

   assign ready_c   = USE_MEM_READY ? bus.iMemReady : 1'b1;
   assign illegal_c = !op_supported(bus.iOp) || ((bus.iOp == OP_RTYPE) && !funct_valid_c);

   multicycle_controller_alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op_c),
      .funct_i       (bus.iFunct),
      .alu_control_o (alu_ctl_c),
      .funct_valid_o (funct_valid_c)
   );

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) state_q <= S_RESET;
      else        state_q <= state_d;
   end

   // IR only loads in FETCH, so iOp is stable for every later branch decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:   state_d = S_FETCH;
         S_FETCH:   if (ready_c) state_d = S_DECODE;
         S_DECODE: begin
            if (illegal_c) state_d = S_FETCH;
            else begin
               case (bus.iOp)
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_RTYPE:     state_d = S_EXECUTE;
                  OP_BEQ:       state_d = S_BEQ;
                  OP_ADDI:      state_d = S_ADDIEX;
                  OP_J:         state_d = S_JUMP;
                  default:      state_d = S_FETCH;
               endcase
            end
         end
         S_MEMADR:  state_d = (bus.iOp == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (ready_c) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (ready_c) state_d = S_FETCH;
         S_EXECUTE: state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BEQ:     state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         default:   state_d = S_RESET;
      endcase
   end

   always_comb begin
      bus.oIorD     = 1'b0;
      bus.oMemWrite = 1'b0;
      bus.oIRWrite  = 1'b0;
      bus.oRegDst   = 1'b0;
      bus.oMemToReg = 1'b0;
      bus.oRegWrite = 1'b0;
      bus.oALUSrcA  = 1'b0;
      bus.oALUSrcB  = 2'b00;
      bus.oPCSrc    = 2'b00;
      bus.oRetire   = 1'b0;
      bus.oIllegal  = 1'b0;
      alu_op_c      = ALUOP_ADD;
      pc_write_c    = 1'b0;
      branch_c      = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.oALUSrcB = 2'b01;
            bus.oIRWrite = ready_c;
            pc_write_c   = ready_c;
         end
         S_DECODE: begin
            bus.oALUSrcB = 2'b11;
            bus.oIllegal = illegal_c;
         end
         S_MEMADR, S_ADDIEX: begin
            bus.oALUSrcA = 1'b1;
            bus.oALUSrcB = 2'b10;
         end
         S_MEMRD:  bus.oIorD = 1'b1;
         S_MEMWB: begin
            bus.oMemToReg = 1'b1;
            bus.oRegWrite = 1'b1;
            bus.oRetire   = 1'b1;
         end
         S_MEMWR: begin
            bus.oIorD     = 1'b1;
            bus.oMemWrite = 1'b1;
            bus.oRetire   = ready_c;
         end
         S_EXECUTE: begin
            bus.oALUSrcA = 1'b1;
            alu_op_c     = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            bus.oRegDst   = 1'b1;
            bus.oRegWrite = 1'b1;
            bus.oRetire   = 1'b1;
         end
         S_BEQ: begin
            bus.oALUSrcA = 1'b1;
            alu_op_c     = ALUOP_SUB;
            branch_c     = 1'b1;
            bus.oPCSrc   = 2'b01;
            bus.oRetire  = 1'b1;
         end
         S_ADDIWB: begin
            bus.oRegWrite = 1'b1;
            bus.oRetire   = 1'b1;
         end
         S_JUMP: begin
            bus.oPCSrc  = 2'b10;
            pc_write_c  = 1'b1;
            bus.oRetire = 1'b1;
         end
         default: ;
      endcase
      bus.oPCEn = pc_write_c | (branch_c & bus.iZero);
   end

   assign bus.oALUControl = alu_ctl_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle vectors for the multicycle controller, plus reset and ready-bypass sequences.
module tb_multicycle_controller;

   typedef struct {
      bit          rst_n;
      logic [5:0]  op;
      logic [5:0]  funct;
      bit          zero;
      bit          ready;
      logic [16:0] exp;
   } vec_t;

   // {IorD,MemWrite,IRWrite,RegDst,MemToReg,RegWrite,ALUSrcA,ALUSrcB[2],PCSrc[2],PCEn,ALUControl[3],Retire,Illegal}
   localparam logic [16:0] O_RESET      = 17'b0_0_0_0_0_0_0_00_00_0_010_0_0;
   localparam logic [16:0] O_FETCH_RDY  = 17'b0_0_1_0_0_0_0_01_00_1_010_0_0;
   localparam logic [16:0] O_FETCH_WAIT = 17'b0_0_0_0_0_0_0_01_00_0_010_0_0;
   localparam logic [16:0] O_DECODE     = 17'b0_0_0_0_0_0_0_11_00_0_010_0_0;
   localparam logic [16:0] O_DECODE_ILL = 17'b0_0_0_0_0_0_0_11_00_0_010_0_1;
   localparam logic [16:0] O_MEMADR     = 17'b0_0_0_0_0_0_1_10_00_0_010_0_0;
   localparam logic [16:0] O_MEMRD      = 17'b1_0_0_0_0_0_0_00_00_0_010_0_0;
   localparam logic [16:0] O_MEMWB      = 17'b0_0_0_0_1_1_0_00_00_0_010_1_0;
   localparam logic [16:0] O_MEMWR_WAIT = 17'b1_1_0_0_0_0_0_00_00_0_010_0_0;
   localparam logic [16:0] O_MEMWR_DONE = 17'b1_1_0_0_0_0_0_00_00_0_010_1_0;
   localparam logic [16:0] O_EXEC_SUB   = 17'b0_0_0_0_0_0_1_00_00_0_110_0_0;
   localparam logic [16:0] O_ALUWB      = 17'b0_0_0_1_0_1_0_00_00_0_010_1_0;
   localparam logic [16:0] O_BEQ_T      = 17'b0_0_0_0_0_0_1_00_01_1_110_1_0;
   localparam logic [16:0] O_BEQ_NT     = 17'b0_0_0_0_0_0_1_00_01_0_110_1_0;
   localparam logic [16:0] O_ADDIEX     = 17'b0_0_0_0_0_0_1_10_00_0_010_0_0;
   localparam logic [16:0] O_ADDIWB     = 17'b0_0_0_0_0_1_0_00_00_0_010_1_0;
   localparam logic [16:0] O_JUMP       = 17'b0_0_0_0_0_0_0_00_10_1_010_1_0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
   localparam logic [5:0] F_SUB = 6'b100010, F_NONE = 6'b000000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_n1 = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vecs[$];

   multicycle_controller_if bus0 ();
   multicycle_controller_if bus1 ();

   multicycle_controller #(.USE_MEM_READY(1'b1)) dut0 (.iClk(clk), .iRstN(rst_n),  .bus(bus0.slave));
   multicycle_controller #(.USE_MEM_READY(1'b0)) dut1 (.iClk(clk), .iRstN(rst_n1), .bus(bus1.slave));

   always #5 clk = ~clk;

   logic [16:0] got0, got1;
   assign got0 = {bus0.oIorD, bus0.oMemWrite, bus0.oIRWrite, bus0.oRegDst, bus0.oMemToReg, bus0.oRegWrite,
                  bus0.oALUSrcA, bus0.oALUSrcB, bus0.oPCSrc, bus0.oPCEn, bus0.oALUControl, bus0.oRetire,
                  bus0.oIllegal};
   assign got1 = {bus1.oIorD, bus1.oMemWrite, bus1.oIRWrite, bus1.oRegDst, bus1.oMemToReg, bus1.oRegWrite,
                  bus1.oALUSrcA, bus1.oALUSrcB, bus1.oPCSrc, bus1.oPCEn, bus1.oALUControl, bus1.oRetire,
                  bus1.oIllegal};

   function automatic vec_t mkv(input bit r, input logic [5:0] op, input logic [5:0] fn,
                                input bit z, input bit rdy, input logic [16:0] e);
      vec_t v;
      v.rst_n = r; v.op = op; v.funct = fn; v.zero = z; v.ready = rdy; v.exp = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge, check outputs mid-cycle.
   task automatic apply(input vec_t v, input string name);
      @(posedge clk);
      #1;
      rst_n          = v.rst_n;
      bus0.iOp       = v.op;
      bus0.iFunct    = v.funct;
      bus0.iZero     = v.zero;
      bus0.iMemReady = v.ready;
      @(negedge clk);
      check(name, got0, v.exp);
   endtask

   initial begin
      bus0.iOp = '0; bus0.iFunct = '0; bus0.iZero = 1'b0; bus0.iMemReady = 1'b0;
      bus1.iOp = LW; bus1.iFunct = '0; bus1.iZero = 1'b0; bus1.iMemReady = 1'b0;

      vecs.push_back(mkv(0, LW,   F_NONE, 0, 1, O_RESET));
      vecs.push_back(mkv(1, LW,   F_NONE, 0, 1, O_RESET));
      // lw with one stalled MEMRD cycle
      vecs.push_back(mkv(1, LW,   F_NONE, 0, 1, O_FETCH_RDY));
      vecs.push_back(mkv(1, LW,   F_NONE, 0, 0, O_DECODE));
      vecs.push_back(mkv(1, LW,   F_NONE, 0, 1, O_MEMADR));
      vecs.push_back(mkv(1, LW,   F_NONE, 0, 0, O_MEMRD));
      vecs.push_back(mkv(1, LW,   F_NONE, 0, 1, O_MEMRD));
      vecs.push_back(mkv(1, LW,   F_NONE, 0, 1, O_MEMWB));
      // sw held in MEMWR until ready
      vecs.push_back(mkv(1, SW,   F_NONE, 0, 1, O_FETCH_RDY));
      vecs.push_back(mkv(1, SW,   F_NONE, 0, 1, O_DECODE));
      vecs.push_back(mkv(1, SW,   F_NONE, 0, 1, O_MEMADR));
      vecs.push_back(mkv(1, SW,   F_NONE, 0, 0, O_MEMWR_WAIT));
      vecs.push_back(mkv(1, SW,   F_NONE, 0, 0, O_MEMWR_WAIT));
      vecs.push_back(mkv(1, SW,   F_NONE, 0, 1, O_MEMWR_DONE));
      // R-type sub, then illegal funct
      vecs.push_back(mkv(1, RT,   F_SUB,  0, 1, O_FETCH_RDY));
      vecs.push_back(mkv(1, RT,   F_SUB,  0, 1, O_DECODE));
      vecs.push_back(mkv(1, RT,   F_SUB,  0, 0, O_EXEC_SUB));
      vecs.push_back(mkv(1, RT,   F_SUB,  0, 0, O_ALUWB));
      vecs.push_back(mkv(1, RT,   F_NONE, 0, 1, O_FETCH_RDY));
      vecs.push_back(mkv(1, RT,   F_NONE, 0, 1, O_DECODE_ILL));
      // beq taken / not taken, jump, addi
      vecs.push_back(mkv(1, BEQ,  F_NONE, 1, 1, O_FETCH_RDY));
      vecs.push_back(mkv(1, BEQ,  F_NONE, 1, 1, O_DECODE));
      vecs.push_back(mkv(1, BEQ,  F_NONE, 1, 1, O_BEQ_T));
      vecs.push_back(mkv(1, BEQ,  F_NONE, 0, 1, O_FETCH_RDY));
      vecs.push_back(mkv(1, BEQ,  F_NONE, 0, 1, O_DECODE));
      vecs.push_back(mkv(1, BEQ,  F_NONE, 0, 1, O_BEQ_NT));
      vecs.push_back(mkv(1, J,    F_NONE, 0, 1, O_FETCH_RDY));
      vecs.push_back(mkv(1, J,    F_NONE, 0, 1, O_DECODE));
      vecs.push_back(mkv(1, J,    F_NONE, 0, 1, O_JUMP));
      vecs.push_back(mkv(1, ADDI, F_NONE, 0, 1, O_FETCH_RDY));
      vecs.push_back(mkv(1, ADDI, F_NONE, 0, 1, O_DECODE));
      vecs.push_back(mkv(1, ADDI, F_NONE, 0, 1, O_ADDIEX));
      vecs.push_back(mkv(1, ADDI, F_NONE, 0, 1, O_ADDIWB));
      // FETCH stalled three cycles, then an unsupported opcode
      vecs.push_back(mkv(1, BAD,  F_NONE, 0, 0, O_FETCH_WAIT));
      vecs.push_back(mkv(1, BAD,  F_NONE, 0, 0, O_FETCH_WAIT));
      vecs.push_back(mkv(1, BAD,  F_NONE, 0, 0, O_FETCH_WAIT));
      vecs.push_back(mkv(1, BAD,  F_NONE, 0, 1, O_FETCH_RDY));
      vecs.push_back(mkv(1, BAD,  F_NONE, 0, 1, O_DECODE_ILL));

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // Async reset in the middle of a sw memory write
      apply(mkv(1, SW, F_NONE, 0, 1, O_FETCH_RDY),  "rst_seq_fetch");
      apply(mkv(1, SW, F_NONE, 0, 1, O_DECODE),     "rst_seq_decode");
      apply(mkv(1, SW, F_NONE, 0, 1, O_MEMADR),     "rst_seq_memadr");
      apply(mkv(1, SW, F_NONE, 0, 0, O_MEMWR_WAIT), "rst_seq_memwr");
      rst_n = 1'b0;
      #1;
      check("rst_async_outputs", got0, O_RESET);
      apply(mkv(1, SW, F_NONE, 0, 1, O_RESET),      "rst_release_reset");
      apply(mkv(1, SW, F_NONE, 0, 1, O_FETCH_RDY),  "rst_release_fetch");

      // Ready bypass: iMemReady held low, lw still takes five cycles
      @(posedge clk);
      #1;
      rst_n1 = 1'b1;
      @(negedge clk);
      check("nordy_reset", got1, O_RESET);
      @(negedge clk); check("nordy_fetch",  got1, O_FETCH_RDY);
      @(negedge clk); check("nordy_decode", got1, O_DECODE);
      @(negedge clk); check("nordy_memadr", got1, O_MEMADR);
      @(negedge clk); check("nordy_memrd",  got1, O_MEMRD);
      @(negedge clk); check("nordy_memwb",  got1, O_MEMWB);
      @(negedge clk); check("nordy_next",   got1, O_FETCH_RDY);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
